// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Bundles the request and result signals of the sequential ALU.
// The multi-cycle controller drives the request side through the master
// modport. The ALU drives the result side through the slave modport.
//
// Signals:
//   start          request, sampled by the ALU only while busy=0
//   ALU_Operation  4-bit operation code, captured with start
//   a, b           WIDTH-bit operands, captured with start
//   ALU_Result     result, or LO/quotient for MULTU/DIVU
//   Result_Hi      HI/remainder for MULTU/DIVU, 0 for other operations
//   Zero           ALU_Result == 0, registered with the result
//   Overflow       signed overflow for ADD/SUB
//   busy           multi-cycle operation in progress
//   done           one-cycle pulse: results were just updated
// -----------------------------------------------------------------------------
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALU_Operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] ALU_Result;
  logic [WIDTH-1:0] Result_Hi;
  logic             Zero;
  logic             Overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, ALU_Operation, a, b,
    input  ALU_Result, Result_Hi, Zero, Overflow, busy, done
  );

  modport slave (
    input  start, ALU_Operation, a, b,
    output ALU_Result, Result_Hi, Zero, Overflow, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Sequential ALU for the execute step of the multi-cycle MIPS datapath.
// Logic, add/sub with signed overflow and the signed/unsigned compares finish
// in a single cycle. MULTU is an iterative shift-add multiplier that retires
// one multiplier bit per cycle. DIVU is an iterative restoring divider that
// retires one quotient bit per cycle. Every operation completes through a
// start/busy/done handshake.
//
// Configuration macro:
//   SEQ_ALU_DIV_EN  defined   -> DIVU implemented, including the DIV state.
//                   undefined -> no divider logic. Opcode 1001 behaves as an
//                                unsupported code (result 0, single cycle).
//
// Ports:
//   clk    clock; all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    seq_alu_if slave modport (start/op/operands in, results out)
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic   clk,
  input  logic   rst_n,
  seq_alu_if.slave bus
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  // opA_q holds the multiplicand (MUL) or the divisor (DIV).
  logic [WIDTH-1:0] opA_q;
  // shift_q holds the multiplier shifting out and the product LO shifting in
  // (MUL), or the dividend shifting out and the quotient shifting in (DIV).
  logic [WIDTH-1:0] shift_q;
  // acc_q is the product HI (MUL) or the partial remainder (DIV).
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] resultHi_q;
  logic             zero_q;
  logic             ovf_q;
  logic             done_q;

  // Single-cycle result path, evaluated directly from the live inputs.
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] scRes_d;
  logic [WIDTH-1:0] scHi_d;
  logic             scOvf_d;
  logic             startMul;
  logic             startDiv;

  always_comb begin
    sum      = bus.a + bus.b;
    diff     = bus.a - bus.b;
    scRes_d  = '0;
    scHi_d   = '0;
    scOvf_d  = 1'b0;
    startMul = (bus.ALU_Operation == OP_MULTU);
    startDiv = 1'b0;
    case (bus.ALU_Operation)
      OP_AND:  scRes_d = bus.a & bus.b;
      OP_OR:   scRes_d = bus.a | bus.b;
      OP_XOR:  scRes_d = bus.a ^ bus.b;
      OP_NOR:  scRes_d = ~(bus.a | bus.b);
      OP_ADD: begin
        scRes_d = sum;
        scOvf_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        scRes_d = diff;
        scOvf_d = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  scRes_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: scRes_d = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
`ifdef SEQ_ALU_DIV_EN
      // Divide by zero never enters DIV: quotient saturates to all ones and
      // the remainder is the dividend, as the iterative divider would give.
      OP_DIVU: begin
        if (bus.b == '0) begin
          scRes_d = '1;
          scHi_d  = bus.a;
        end else begin
          startDiv = 1'b1;
        end
      end
`endif
      default: scRes_d = '0;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into HI, then
  // shift the {HI, multiplier} pair right so the carry lands in HI's MSB and
  // HI's LSB becomes the next LO bit.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulAcc_d;
  logic [WIDTH-1:0] mulShift_d;

  always_comb begin
    mulSum     = {1'b0, acc_q} + (shift_q[0] ? {1'b0, opA_q} : {(WIDTH+1){1'b0}});
    mulAcc_d   = mulSum[WIDTH:1];
    mulShift_d = {mulSum[0], shift_q[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  // One restoring-divide step: bring the next dividend bit into the partial
  // remainder, try subtracting the divisor, keep the difference only when it
  // did not go negative. The extra top bit covers remainders that overflow
  // WIDTH bits after the shift.
  logic [WIDTH:0]   divShifted;
  logic [WIDTH:0]   divDiff;
  logic [WIDTH-1:0] divAcc_d;
  logic [WIDTH-1:0] divShift_d;

  always_comb begin
    divShifted = {acc_q, shift_q[WIDTH-1]};
    divDiff    = divShifted - {1'b0, opA_q};
    if (!divDiff[WIDTH]) begin
      divAcc_d   = divDiff[WIDTH-1:0];
      divShift_d = {shift_q[WIDTH-2:0], 1'b1};
    end else begin
      divAcc_d   = divShifted[WIDTH-1:0];
      divShift_d = {shift_q[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Control FSM and all registered outputs. done defaults low every cycle so
  // it only pulses on the completing edge; outputs otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opA_q      <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      resultHi_q <= '0;
      zero_q     <= 1'b1;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (startMul) begin
              opA_q   <= bus.a;
              shift_q <= bus.b;
              acc_q   <= '0;
              cnt_q   <= CNT_INIT;
              state_q <= MUL;
`ifdef SEQ_ALU_DIV_EN
            end else if (startDiv) begin
              opA_q   <= bus.b;
              shift_q <= bus.a;
              acc_q   <= '0;
              cnt_q   <= CNT_INIT;
              state_q <= DIV;
`endif
            end else begin
              result_q   <= scRes_d;
              resultHi_q <= scHi_d;
              zero_q     <= (scRes_d == '0);
              ovf_q      <= scOvf_d;
              done_q     <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q   <= mulAcc_d;
          shift_q <= mulShift_d;
          cnt_q   <= cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            result_q   <= mulShift_d;
            resultHi_q <= mulAcc_d;
            zero_q     <= (mulShift_d == '0);
            ovf_q      <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        DIV: begin
          acc_q   <= divAcc_d;
          shift_q <= divShift_d;
          cnt_q   <= cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            result_q   <= divShift_d;
            resultHi_q <= divAcc_d;
            zero_q     <= (divShift_d == '0);
            ovf_q      <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ALU_Result = result_q;
  assign bus.Result_Hi  = resultHi_q;
  assign bus.Zero       = zero_q;
  assign bus.Overflow   = ovf_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;

endmodule
